// File: rtl/llmint8_pkg.sv
// Shared constants and width helpers for the llmint8 dequantizer datapath.
// Everything here is evaluated at elaboration time only.
package llmint8_pkg;

   // Rounded reciprocal of D = 2^(qw-1)-1, scaled by 2^frac.
   function automatic longint recip_const(input int qw, input int frac);
      longint d;
      d = (longint'(1) << (qw - 1)) - 1;
      return ((longint'(1) << frac) + d / 2) / d;
   endfunction

   function automatic int prod_width(input int a_w, input int b_w);
      return a_w + b_w + 1;
   endfunction

   function automatic longint sat_max(input int w);
      return (longint'(1) << (w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) << (w - 1));
   endfunction

endpackage

// File: rtl/dequant_lane.sv
// One element of the dequantizer: scale multiply, reciprocal multiply,
// round-half-up and saturate, each stage gated by an enable from the top.
module dequant_lane
   import llmint8_pkg::*;
#(
   parameter int IN_WIDTH           = 8,
   parameter int MAX_NUM_WIDTH      = 16,
   parameter int QUANTIZATION_WIDTH = 8,
   parameter int RECIP_FRAC_WIDTH   = 16,
   parameter int OUT_WIDTH          = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en_s1,
   input  logic                        en_s2,
   input  logic                        en_s3,
   input  logic signed [IN_WIDTH-1:0]  data_in,
   input  logic [MAX_NUM_WIDTH-1:0]    max_num,
   output logic signed [OUT_WIDTH-1:0] data_out,
   output logic                        sat
);
   localparam int P_W = prod_width(IN_WIDTH, MAX_NUM_WIDTH);
   localparam int Q_W = prod_width(P_W, RECIP_FRAC_WIDTH);
   localparam int Y_W = Q_W - RECIP_FRAC_WIDTH;

   localparam logic signed [Q_W-1:0] RECIP = Q_W'(recip_const(QUANTIZATION_WIDTH, RECIP_FRAC_WIDTH));
   localparam logic signed [Q_W-1:0] HALF  = Q_W'(longint'(1) << (RECIP_FRAC_WIDTH - 1));
   localparam logic signed [Y_W-1:0] Y_MAX = Y_W'(sat_max(OUT_WIDTH));
   localparam logic signed [Y_W-1:0] Y_MIN = Y_W'(sat_min(OUT_WIDTH));
   localparam logic signed [OUT_WIDTH-1:0] O_MAX = OUT_WIDTH'(sat_max(OUT_WIDTH));
   localparam logic signed [OUT_WIDTH-1:0] O_MIN = OUT_WIDTH'(sat_min(OUT_WIDTH));

   logic signed [P_W-1:0]       max_s;
   logic signed [P_W-1:0]       p_q;
   logic signed [Q_W-1:0]       q_q;
   logic signed [Y_W-1:0]       y;
   logic signed [OUT_WIDTH-1:0] y_sat;

   // max_num is an unsigned magnitude, so it is zero-extended before the signed multiply
   assign max_s = $signed(P_W'(max_num));
   assign y     = Y_W'((q_q + HALF) >>> RECIP_FRAC_WIDTH);
   assign sat   = (y > Y_MAX) || (y < Y_MIN);

   always_comb begin
      y_sat = OUT_WIDTH'(y);
      if (y > Y_MAX)
         y_sat = O_MAX;
      else if (y < Y_MIN)
         y_sat = O_MIN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p_q      <= '0;
         q_q      <= '0;
         data_out <= '0;
      end else begin
         if (en_s1)
            p_q <= P_W'(data_in) * max_s;
         if (en_s2)
            q_q <= Q_W'(p_q) * RECIP;
         if (en_s3)
            data_out <= y_sat;
      end
   end

endmodule

// File: rtl/dequantizer_pipelined.sv
// Three-stage dequantizer with joined data/scale input handshake, elastic
// valid/ready back-pressure and a sticky saturation flag.
module dequantizer_pipelined
   import llmint8_pkg::*;
#(
   parameter int IN_WIDTH           = 8,
   parameter int IN_SIZE            = 4,
   parameter int IN_PARALLELISM     = 1,
   parameter int MAX_NUM_WIDTH      = 16,
   parameter int QUANTIZATION_WIDTH = 8,
   parameter int RECIP_FRAC_WIDTH   = 16,
   parameter int OUT_WIDTH          = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [IN_WIDTH-1:0]  data_in [IN_PARALLELISM*IN_SIZE],
   input  logic                        data_in_valid,
   output logic                        data_in_ready,
   input  logic [MAX_NUM_WIDTH-1:0]    max_num,
   input  logic                        max_num_valid,
   output logic                        max_num_ready,
   output logic signed [OUT_WIDTH-1:0] data_out [IN_PARALLELISM*IN_SIZE],
   output logic                        data_out_valid,
   input  logic                        data_out_ready,
   output logic                        overflow
);
   localparam int N = IN_PARALLELISM * IN_SIZE;

   logic         v1, v2, v3;
   logic         ld1, ld2, ld3;
   logic         accept;
   logic [N-1:0] lane_sat;

   // A stage loads when it is empty or its successor is taking its contents.
   assign ld3 = !v3 || data_out_ready;
   assign ld2 = !v2 || ld3;
   assign ld1 = !v1 || ld2;

   assign data_in_ready  = max_num_valid && ld1 && !rst;
   assign max_num_ready  = data_in_valid && ld1 && !rst;
   assign accept         = data_in_valid && data_in_ready;
   assign data_out_valid = v3;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1       <= 1'b0;
         v2       <= 1'b0;
         v3       <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (ld1)
            v1 <= accept;
         if (ld2)
            v2 <= v1;
         if (ld3)
            v3 <= v2;
         if (ld3 && v2 && |lane_sat)
            overflow <= 1'b1;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      dequant_lane #(
         .IN_WIDTH           (IN_WIDTH),
         .MAX_NUM_WIDTH      (MAX_NUM_WIDTH),
         .QUANTIZATION_WIDTH (QUANTIZATION_WIDTH),
         .RECIP_FRAC_WIDTH   (RECIP_FRAC_WIDTH),
         .OUT_WIDTH          (OUT_WIDTH)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .en_s1    (accept),
         .en_s2    (ld2 && v1),
         .en_s3    (ld3 && v2),
         .data_in  (data_in[i]),
         .max_num  (max_num),
         .data_out (data_out[i]),
         .sat      (lane_sat[i])
      );
   end

endmodule
